// File: rtl/seq_perm_pkg.sv
// seq_perm_pkg -- shared definitions for the seq_perm_gen permutation engine.
//
// Contents:
//   state_e      FSM state encoding (StInv exists only with PERM_INVERSE_EN)
//   RndW         width of the round counter (ROUNDS is at most 16)
//   round_mult   per-round multiplier M(rnd) = 2*rnd+3 (caller truncates to LOG_N bits)
//   round_const  per-round offset C(rnd) = rnd+1 (caller truncates to LOG_N bits)
//   elem_lsb     bit offset of an element in a packed element vector (pack/unpack)
//
// Optional feature macro: PERM_INVERSE_EN (adds the StInv state).
package seq_perm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
`ifdef PERM_INVERSE_EN
        StInv  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    localparam int unsigned RndW = 4;

    // Always odd, so once truncated mod 2**LOG_N it stays invertible.
    function automatic int unsigned round_mult(input int unsigned rnd);
        return 2 * rnd + 3;
    endfunction

    function automatic int unsigned round_const(input int unsigned rnd);
        return rnd + 1;
    endfunction

    // Element idx of a packed vector of log_n-bit elements lives at [lsb +: log_n].
    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned log_n);
        return idx * log_n;
    endfunction

endpackage

// File: rtl/perm_round.sv
// perm_round -- one combinational rotate+permute round of seq_perm_gen.
//
//   w       input   N*LOG_N  current work vector, element i at [i*LOG_N +: LOG_N]
//   s       input   LOG_N    rotation amount for this round
//   rnd     input   RndW     round index, selects M and C
//   w_next  output  N*LOG_N  W'[i] = R[(i*M + C) mod N], where R[j] = W[(j + s) mod N]
module perm_round
    import seq_perm_pkg::*;
#(
    parameter int unsigned LOG_N = 4
) (
    input  logic [(2**LOG_N)*LOG_N-1:0] w,
    input  logic [LOG_N-1:0]            s,
    input  logic [RndW-1:0]             rnd,
    output logic [(2**LOG_N)*LOG_N-1:0] w_next
);

    localparam int unsigned N = 2**LOG_N;

    logic [LOG_N-1:0] m;
    logic [LOG_N-1:0] c;

    assign m = LOG_N'(round_mult(32'(rnd)));
    assign c = LOG_N'(round_const(32'(rnd)));

    // Rotation and permutation fold into one source index; LOG_N-bit math wraps mod N.
    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [LOG_N-1:0] src;
        assign src = LOG_N'(i) * m + c + s;
        assign w_next[elem_lsb(i, LOG_N) +: LOG_N] = w[elem_lsb(32'(src), LOG_N) +: LOG_N];
    end

endmodule

// File: rtl/seq_perm_gen.sv
// seq_perm_gen -- seeded permutation generator over 0..N-1, N = 2**LOG_N.
//
// A seed is accepted in IDLE; ROUNDS rotate+permute rounds are applied to an
// identity vector, one per cycle, and the result is held in DONE until taken.
//
//   clk        input   1             rising-edge clock
//   rst        input   1             asynchronous active-low reset
//   seed       input   ROUNDS*LOG_N  per-round rotation amounts
//   in_valid   input   1             seed offered
//   in_ready   output  1             engine is idle and accepts a seed
//   seq_all    output  N*LOG_N       permutation, element i at [i*LOG_N +: LOG_N]
//   out_valid  output  1             seq_all holds a finished result
//   out_ready  input   1             consumer takes the result
//   busy       output  1             engine is not idle
//   inv_all    output  N*LOG_N       inverse permutation (PERM_INVERSE_EN only)
//
// Optional feature macro: PERM_INVERSE_EN adds inv_all and one extra INV cycle.
module seq_perm_gen
    import seq_perm_pkg::*;
#(
    parameter int unsigned LOG_N  = 4,
    parameter int unsigned ROUNDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROUNDS*LOG_N-1:0]     seed,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [(2**LOG_N)*LOG_N-1:0] seq_all,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
`ifdef PERM_INVERSE_EN
    ,
    output logic [(2**LOG_N)*LOG_N-1:0] inv_all
`endif
);

    localparam int unsigned N    = 2**LOG_N;
    localparam int unsigned VecW = N * LOG_N;

    function automatic logic [VecW-1:0] identity_vec();
        logic [VecW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v[elem_lsb(i, LOG_N) +: LOG_N] = LOG_N'(i);
        end
        return v;
    endfunction

    localparam logic [VecW-1:0] IdentVec = identity_vec();

    state_e                  state_q;
    logic [RndW-1:0]         rnd_q;
    logic [ROUNDS*LOG_N-1:0] seed_q;
    logic [VecW-1:0]         work_q;
    logic [VecW-1:0]         work_next;
    logic [LOG_N-1:0]        rot;

    assign rot     = seed_q[elem_lsb(32'(rnd_q), LOG_N) +: LOG_N];
    assign seq_all = work_q;

    perm_round #(
        .LOG_N (LOG_N)
    ) u_round (
        .w      (work_q),
        .s      (rot),
        .rnd    (rnd_q),
        .w_next (work_next)
    );

`ifdef PERM_INVERSE_EN
    logic [VecW-1:0] inv_next;

    // Scatter: the slot addressed by W[i] receives i.
    always_comb begin
        inv_next = '0;
        for (int unsigned i = 0; i < N; i++) begin
            inv_next[elem_lsb(32'(work_q[elem_lsb(i, LOG_N) +: LOG_N]), LOG_N) +: LOG_N] =
                LOG_N'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rnd_q     <= '0;
            seed_q    <= '0;
            work_q    <= IdentVec;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef PERM_INVERSE_EN
            inv_all   <= IdentVec;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        seed_q   <= seed;
                        work_q   <= IdentVec;
                        rnd_q    <= '0;
                        state_q  <= StRun;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StRun: begin
                    work_q <= work_next;
                    if (rnd_q == RndW'(ROUNDS - 1)) begin
                        rnd_q <= '0;
`ifdef PERM_INVERSE_EN
                        state_q <= StInv;
`else
                        state_q   <= StDone;
                        out_valid <= 1'b1;
`endif
                    end else begin
                        rnd_q <= rnd_q + 1'b1;
                    end
                end
`ifdef PERM_INVERSE_EN
                StInv: begin
                    inv_all   <= inv_next;
                    state_q   <= StDone;
                    out_valid <= 1'b1;
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_perm_gen.sv
// tb_seq_perm_gen -- self-checking bench for seq_perm_gen.
//
// Two instances: u_r1 (ROUNDS=1) for the hand-computed single-round vectors,
// u_dut (defaults) checked every valid cycle against a behavioural model.
// Honours PERM_INVERSE_EN (extra latency cycle, inv_all checks).
module tb_seq_perm_gen;

    localparam int LogN   = 4;
    localparam int N      = 16;
    localparam int Rounds = 8;
`ifdef PERM_INVERSE_EN
    localparam int Lat   = Rounds + 1;
    localparam int LatR1 = 2;
`else
    localparam int Lat   = Rounds;
    localparam int LatR1 = 1;
`endif
    localparam logic [63:0] Ident = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default instance.
    logic [31:0] seed;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] seq_all;
    // ROUNDS=1 instance.
    logic [3:0]  r1_seed;
    logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready, r1_busy;
    logic [63:0] r1_seq_all;
`ifdef PERM_INVERSE_EN
    logic [63:0] inv_all, r1_inv_all;
`endif

    seq_perm_gen #(.LOG_N(LogN), .ROUNDS(Rounds)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq_all   (seq_all),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef PERM_INVERSE_EN
        ,
        .inv_all   (inv_all)
`endif
    );

    seq_perm_gen #(.LOG_N(LogN), .ROUNDS(1)) u_r1 (
        .clk       (clk),
        .rst       (rst),
        .seed      (r1_seed),
        .in_valid  (r1_in_valid),
        .in_ready  (r1_in_ready),
        .seq_all   (r1_seq_all),
        .out_valid (r1_out_valid),
        .out_ready (r1_out_ready),
        .busy      (r1_busy)
`ifdef PERM_INVERSE_EN
        ,
        .inv_all   (r1_inv_all)
`endif
    );

    int total;
    int bad;
    logic [63:0] exp_seq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic logic [63:0] pack(input int a[16]);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*4 +: 4] = 4'(a[i]);
        return v;
    endfunction

    // Reference: explicit rotate array, then explicit permute array, per round.
    function automatic logic [63:0] model_vec(input logic [31:0] sd, input int rounds);
        int w[16];
        int r[16];
        int s, m, c;
        for (int i = 0; i < N; i++) w[i] = i;
        for (int rd = 0; rd < rounds; rd++) begin
            s = int'((sd >> (rd * 4)) & 32'hF);
            m = (2 * rd + 3) % N;
            c = (rd + 1) % N;
            for (int i = 0; i < N; i++) r[i] = w[(i + s) % N];
            for (int i = 0; i < N; i++) w[i] = r[(i * m + c) % N];
        end
        return pack(w);
    endfunction

    function automatic logic [63:0] is_perm(input logic [63:0] v);
        logic [15:0] seen;
        seen = '0;
        for (int i = 0; i < N; i++) seen[v[i*4 +: 4]] = 1'b1;
        return 64'(&seen);
    endfunction

    function automatic logic [63:0] inv_ok(input logic [63:0] sq, input logic [63:0] iv);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (iv[sq[i*4 +: 4]*4 +: 4] != 4'(i)) ok = 1'b0;
        end
        return 64'(ok);
    endfunction

    // Compare process: every cycle the default instance shows a result.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            chk("seq_vs_model", seq_all, exp_seq);
            chk("seq_is_perm", is_perm(seq_all), 64'd1);
`ifdef PERM_INVERSE_EN
            chk("inv_matches_seq", inv_ok(seq_all, inv_all), 64'd1);
`endif
        end
    end

    task automatic r1_case(input logic [3:0] sd, input logic [63:0] want, input string nm);
        int k;
        bit got;
        @(negedge clk);
        chk({nm, "_in_ready"}, 64'(r1_in_ready), 64'd1);
        @(posedge clk); #1;
        r1_seed = sd; r1_in_valid = 1'b1; r1_out_ready = 1'b0;
        @(posedge clk); #1;
        r1_in_valid = 1'b0;
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            @(negedge clk);
            got = r1_out_valid;
        end
        chk({nm, "_latency"}, 64'(k), 64'(LatR1));
        chk({nm, "_seq"}, r1_seq_all, want);
`ifdef PERM_INVERSE_EN
        chk({nm, "_inv"}, inv_ok(r1_seq_all, r1_inv_all), 64'd1);
`endif
        @(posedge clk); #1 r1_out_ready = 1'b1;
        @(posedge clk); #1 r1_out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] sd, input int hold, input bit pulse);
        int k;
        int vcnt;
        bit got;
        logic [63:0] first;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        exp_seq = model_vec(sd, Rounds);
        @(posedge clk); #1;
        seed = sd; in_valid = 1'b1; out_ready = (hold <= 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seed = ~sd;  // must not matter once latched
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (pulse && k == 2) begin
                in_valid = 1'b1;
                seed = sd ^ 32'hA5A5_5A5A;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            got = out_valid;
            if (k == 1) begin
                chk("run_busy", 64'(busy), 64'd1);
                chk("run_in_ready", 64'(in_ready), 64'd0);
            end
        end
        in_valid = 1'b0;
        chk("latency", 64'(k), 64'(Lat));
        if (got) begin
            first = seq_all;
            vcnt = 1;
            for (int h = 1; h < hold; h++) begin
                @(posedge clk); #1;
                if (h == hold - 1) out_ready = 1'b1;
                @(negedge clk);
                if (out_valid) vcnt++;
                chk("hold_stable", seq_all, first);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("valid_cycles", 64'(vcnt), 64'(hold));
            chk("release_valid", 64'(out_valid), 64'd0);
            chk("release_in_ready", 64'(in_ready), 64'd1);
            chk("release_busy", 64'(busy), 64'd0);
        end else begin
            out_ready = 1'b0;
        end
    endtask

    task automatic reset_case(input logic [31:0] sd);
        int seen;
        @(negedge clk);
        @(posedge clk); #1;
        seed = sd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_seq_identity", seq_all, Ident);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        do_op(sd, 2, 1'b0);
    endtask

    initial begin
        int lit0[16] = '{1, 4, 7, 10, 13, 0, 3, 6, 9, 12, 15, 2, 5, 8, 11, 14};
        int lit1[16] = '{2, 5, 8, 11, 14, 1, 4, 7, 10, 13, 0, 3, 6, 9, 12, 15};
        total = 0; bad = 0;
        seed = '0; in_valid = 1'b0; out_ready = 1'b0; exp_seq = '0;
        r1_seed = '0; r1_in_valid = 1'b0; r1_out_ready = 1'b0;

        // Pin the model to the hand-computed single-round vectors.
        chk("model_r1_seed0", model_vec(32'h0, 1), pack(lit0));
        chk("model_r1_seed1", model_vec(32'h1, 1), pack(lit1));

        #12;
        chk("reset_seq", seq_all, Ident);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_r1_seq", r1_seq_all, Ident);
`ifdef PERM_INVERSE_EN
        chk("reset_inv", inv_all, Ident);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        r1_case(4'h0, pack(lit0), "r1_seed0");
        r1_case(4'h1, pack(lit1), "r1_seed1");

        do_op(32'h0000_0000, 5, 1'b0);
        do_op(32'h1234_5678, 5, 1'b0);
        do_op($urandom, 5, 1'b0);
        do_op(32'hDEAD_BEEF, 3, 1'b1);
        do_op(32'hF0E1_D2C3, 1, 1'b0);
        reset_case(32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
